// File: rtl/rr_pkt_arbiter.sv
// rr_pkt_arbiter: packet-granular round-robin merge of NUM_QUEUES AXI4-Stream
// queues into one output stream. A grant is held from the first beat until the
// tlast handshake, so packets never interleave on the output.
//
// Ports:
//   axis_aclk, axis_resetn   clock, asynchronous active-low reset
//   s_axis_*                 flattened per-queue input streams (queue i = slice i)
//   m_axis_*                 merged output stream, passed through from the grant
//   queue_en                 per-queue eligibility for new grants
//   pkt_cnt                  per-queue forwarded packet counters (32 bits each)
module rr_pkt_arbiter #(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned NUM_QUEUES           = 4
) (
  input  logic                                            axis_aclk,
  input  logic                                            axis_resetn,
  input  logic [NUM_QUEUES*C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [NUM_QUEUES*C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
  input  logic [NUM_QUEUES*C_M_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
  input  logic [NUM_QUEUES-1:0]                           s_axis_tvalid,
  input  logic [NUM_QUEUES-1:0]                           s_axis_tlast,
  output logic [NUM_QUEUES-1:0]                           s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]                  m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]                m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]                 m_axis_tuser,
  output logic                                            m_axis_tvalid,
  output logic                                            m_axis_tlast,
  input  logic                                            m_axis_tready,
  input  logic [NUM_QUEUES-1:0]                           queue_en,
  output logic [NUM_QUEUES*32-1:0]                        pkt_cnt
);

  localparam int unsigned DW = C_S_AXIS_DATA_WIDTH;
  localparam int unsigned KW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int unsigned UW = C_M_AXIS_TUSER_WIDTH;
  localparam int unsigned GW = $clog2(NUM_QUEUES);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]    state, state_nxt;
  logic [GW-1:0] grant, grant_nxt;
  logic [GW-1:0] last_grant, last_grant_nxt;
  logic          eop;
  logic [NUM_QUEUES-1:0] eligible;

  assign eligible = s_axis_tvalid & queue_en;

  // Tlast handshake on the granted queue closes the packet.
  assign eop = (state == SEND) && s_axis_tvalid[grant] && m_axis_tready
               && s_axis_tlast[grant];

  // State register.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_QUEUES - 1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Next-state logic: round-robin search starts one past the last grant.
  always_comb begin
    logic        found;
    int unsigned idx;
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    found          = 1'b0;
    idx            = 0;
    case (state)
      IDLE: begin
        for (int unsigned k = 1; k <= NUM_QUEUES; k++) begin
          idx = (32'(last_grant) + k) % NUM_QUEUES;
          if (!found && eligible[idx]) begin
            found     = 1'b1;
            grant_nxt = GW'(idx);
          end
        end
        if (found) state_nxt = SEND;
      end
      SEND: begin
        if (eop) begin
          state_nxt      = IDLE;
          last_grant_nxt = grant;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Zero-latency pass-through of the granted queue while sending.
  always_comb begin
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    if (state == SEND) begin
      s_axis_tready[grant] = m_axis_tready;
      m_axis_tdata  = s_axis_tdata[32'(grant)*DW +: DW];
      m_axis_tkeep  = s_axis_tkeep[32'(grant)*KW +: KW];
      m_axis_tuser  = s_axis_tuser[32'(grant)*UW +: UW];
      m_axis_tvalid = s_axis_tvalid[grant];
      m_axis_tlast  = s_axis_tlast[grant];
    end
  end

  // Per-queue packet counters, wrapping modulo 2^32.
  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_cnt
    logic [31:0] cnt_q;
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
        cnt_q <= '0;
      end else if (eop && (32'(grant) == i)) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
    assign pkt_cnt[i*32 +: 32] = cnt_q;
  end

endmodule

// File: tb/tb_rr_pkt_arbiter.sv
// Directed bench for rr_pkt_arbiter: a table of per-cycle vectors plus
// hand-written sequences for counter wrap and mid-packet reset.
module tb_rr_pkt_arbiter;

  localparam int NQ = 4;

  logic              axis_aclk = 1'b0;
  logic              axis_resetn = 1'b0;
  logic [NQ*256-1:0] s_axis_tdata;
  logic [NQ*32-1:0]  s_axis_tkeep;
  logic [NQ*128-1:0] s_axis_tuser;
  logic [NQ-1:0]     s_axis_tvalid;
  logic [NQ-1:0]     s_axis_tlast;
  logic [NQ-1:0]     s_axis_tready;
  logic [255:0]      m_axis_tdata;
  logic [31:0]       m_axis_tkeep;
  logic [127:0]      m_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;
  logic [NQ-1:0]     queue_en;
  logic [NQ*32-1:0]  pkt_cnt;

  rr_pkt_arbiter #(
    .C_M_AXIS_DATA_WIDTH(256), .C_S_AXIS_DATA_WIDTH(256),
    .C_M_AXIS_TUSER_WIDTH(128), .NUM_QUEUES(NQ)
  ) dut (
    .axis_aclk(axis_aclk), .axis_resetn(axis_resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .queue_en(queue_en), .pkt_cnt(pkt_cnt)
  );

  always #5 axis_aclk = ~axis_aclk;

  typedef struct {
    logic            rst;
    logic [3:0]      tv, tl, en;
    logic            rdy;
    int              src;      // expected source queue, -1 = idle
    logic            e_last;
    logic [3:0]      e_rdy;
    logic [3:0][7:0] e_cnt;
  } vec_t;

  vec_t vt[$];
  int   errors = 0;
  int   checks = 0;
  int   tag = 0;

  function automatic logic [255:0] pat_data(int q, int t);
    return {8{8'(q), 8'(t), 16'hA5C3}};
  endfunction
  function automatic logic [31:0] pat_keep(int q);
    return {8'(q), 24'hFFFFF0};
  endfunction
  function automatic logic [127:0] pat_user(int q, int t);
    return {96'd0, 8'(t), 8'(q), 16'hBEEF};
  endfunction

  function automatic vec_t mk(logic rst, logic [3:0] tv, logic [3:0] tl,
                              logic [3:0] en, logic rdy, int src, logic e_last,
                              logic [3:0] e_rdy, int c0, int c1, int c2, int c3);
    vec_t v;
    v.rst = rst; v.tv = tv; v.tl = tl; v.en = en; v.rdy = rdy;
    v.src = src; v.e_last = e_last; v.e_rdy = e_rdy;
    v.e_cnt = {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs 1ns after the edge; outputs are checked 3ns later.
  task automatic drive(input logic [3:0] tv, input logic [3:0] tl,
                       input logic [3:0] en, input logic rdy);
    tag++;
    for (int q = 0; q < NQ; q++) begin
      s_axis_tdata[q*256 +: 256] = pat_data(q, tag);
      s_axis_tkeep[q*32 +: 32]   = pat_keep(q);
      s_axis_tuser[q*128 +: 128] = pat_user(q, tag);
    end
    s_axis_tvalid = tv;
    s_axis_tlast  = tl;
    queue_en      = en;
    m_axis_tready = rdy;
  endtask

  task automatic step(input logic [3:0] tv, input logic [3:0] tl,
                      input logic [3:0] en, input logic rdy);
    @(posedge axis_aclk);
    #1;
    drive(tv, tl, en, rdy);
    #3;
  endtask

  task automatic do_reset();
    s_axis_tvalid = '0;
    axis_resetn = 1'b0;
    @(posedge axis_aclk);
    #1;
    axis_resetn = 1'b1;
  endtask

  task automatic check_out(input string name, input int src, input logic e_last,
                           input logic [3:0] e_rdy);
    chk({name, ".tvalid"}, 256'(m_axis_tvalid), 256'(src >= 0));
    chk({name, ".tlast"}, 256'(m_axis_tlast), 256'(e_last));
    chk({name, ".s_tready"}, 256'(s_axis_tready), 256'(e_rdy));
    chk({name, ".tdata"}, m_axis_tdata, (src >= 0) ? pat_data(src, tag) : '0);
    chk({name, ".tkeep"}, 256'(m_axis_tkeep), (src >= 0) ? 256'(pat_keep(src)) : '0);
    chk({name, ".tuser"}, 256'(m_axis_tuser), (src >= 0) ? 256'(pat_user(src, tag)) : '0);
  endtask

  initial begin
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
    s_axis_tvalid = '0; s_axis_tlast = '0; queue_en = '0; m_axis_tready = 1'b0;

    // Single 3-beat packet on queue 2.
    vt.push_back(mk(1, 4'b0100, 4'b0000, 4'hF, 1, -1, 0, 4'b0000, 0, 0, 0, 0));
    vt.push_back(mk(0, 4'b0100, 4'b0000, 4'hF, 1,  2, 0, 4'b0100, 0, 0, 0, 0));
    vt.push_back(mk(0, 4'b0100, 4'b0000, 4'hF, 1,  2, 0, 4'b0100, 0, 0, 0, 0));
    vt.push_back(mk(0, 4'b0100, 4'b0100, 4'hF, 1,  2, 1, 4'b0100, 0, 0, 0, 0));
    vt.push_back(mk(0, 4'b0000, 4'b0000, 4'hF, 1, -1, 0, 4'b0000, 0, 0, 1, 0));
    // All queues valid, 2-beat packets: order 0,1,2,3,0.
    vt.push_back(mk(1, 4'b1111, 4'b0000, 4'hF, 1, -1, 0, 4'b0000, 0, 0, 0, 0));
    vt.push_back(mk(0, 4'b1111, 4'b0000, 4'hF, 1,  0, 0, 4'b0001, 0, 0, 0, 0));
    vt.push_back(mk(0, 4'b1111, 4'b0001, 4'hF, 1,  0, 1, 4'b0001, 0, 0, 0, 0));
    vt.push_back(mk(0, 4'b1111, 4'b0000, 4'hF, 1, -1, 0, 4'b0000, 1, 0, 0, 0));
    vt.push_back(mk(0, 4'b1111, 4'b0000, 4'hF, 1,  1, 0, 4'b0010, 1, 0, 0, 0));
    vt.push_back(mk(0, 4'b1111, 4'b0010, 4'hF, 1,  1, 1, 4'b0010, 1, 0, 0, 0));
    vt.push_back(mk(0, 4'b1111, 4'b0000, 4'hF, 1, -1, 0, 4'b0000, 1, 1, 0, 0));
    vt.push_back(mk(0, 4'b1111, 4'b0000, 4'hF, 1,  2, 0, 4'b0100, 1, 1, 0, 0));
    vt.push_back(mk(0, 4'b1111, 4'b0100, 4'hF, 1,  2, 1, 4'b0100, 1, 1, 0, 0));
    vt.push_back(mk(0, 4'b1111, 4'b0000, 4'hF, 1, -1, 0, 4'b0000, 1, 1, 1, 0));
    vt.push_back(mk(0, 4'b1111, 4'b0000, 4'hF, 1,  3, 0, 4'b1000, 1, 1, 1, 0));
    vt.push_back(mk(0, 4'b1111, 4'b1000, 4'hF, 1,  3, 1, 4'b1000, 1, 1, 1, 0));
    vt.push_back(mk(0, 4'b1111, 4'b0000, 4'hF, 1, -1, 0, 4'b0000, 1, 1, 1, 1));
    vt.push_back(mk(0, 4'b1111, 4'b0000, 4'hF, 1,  0, 0, 4'b0001, 1, 1, 1, 1));
    vt.push_back(mk(0, 4'b1111, 4'b0001, 4'hF, 1,  0, 1, 4'b0001, 1, 1, 1, 1));
    vt.push_back(mk(0, 4'b1111, 4'b0000, 4'hF, 1, -1, 0, 4'b0000, 2, 1, 1, 1));
    // queue_en=1011, single-beat packets: order 0,1,3,0.
    vt.push_back(mk(1, 4'b1111, 4'b1111, 4'hB, 1, -1, 0, 4'b0000, 0, 0, 0, 0));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 4'hB, 1,  0, 1, 4'b0001, 0, 0, 0, 0));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 4'hB, 1, -1, 0, 4'b0000, 1, 0, 0, 0));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 4'hB, 1,  1, 1, 4'b0010, 1, 0, 0, 0));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 4'hB, 1, -1, 0, 4'b0000, 1, 1, 0, 0));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 4'hB, 1,  3, 1, 4'b1000, 1, 1, 0, 0));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 4'hB, 1, -1, 0, 4'b0000, 1, 1, 0, 1));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 4'hB, 1,  0, 1, 4'b0001, 1, 1, 0, 1));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 4'hB, 1, -1, 0, 4'b0000, 2, 1, 0, 1));
    // m_axis_tready toggling mid-packet on queue 1.
    vt.push_back(mk(1, 4'b0010, 4'b0000, 4'hF, 1, -1, 0, 4'b0000, 0, 0, 0, 0));
    vt.push_back(mk(0, 4'b0010, 4'b0000, 4'hF, 1,  1, 0, 4'b0010, 0, 0, 0, 0));
    vt.push_back(mk(0, 4'b0010, 4'b0000, 4'hF, 0,  1, 0, 4'b0000, 0, 0, 0, 0));
    vt.push_back(mk(0, 4'b0010, 4'b0000, 4'hF, 1,  1, 0, 4'b0010, 0, 0, 0, 0));
    vt.push_back(mk(0, 4'b0010, 4'b0010, 4'hF, 0,  1, 1, 4'b0000, 0, 0, 0, 0));
    vt.push_back(mk(0, 4'b0010, 4'b0010, 4'hF, 1,  1, 1, 4'b0010, 0, 0, 0, 0));
    vt.push_back(mk(0, 4'b0000, 4'b0000, 4'hF, 1, -1, 0, 4'b0000, 0, 1, 0, 0));
    // Clear queue_en[1] while queue 1 is mid-packet.
    vt.push_back(mk(1, 4'b0010, 4'b0000, 4'hF, 1, -1, 0, 4'b0000, 0, 0, 0, 0));
    vt.push_back(mk(0, 4'b0010, 4'b0000, 4'hF, 1,  1, 0, 4'b0010, 0, 0, 0, 0));
    vt.push_back(mk(0, 4'b1111, 4'b0000, 4'hD, 1,  1, 0, 4'b0010, 0, 0, 0, 0));
    vt.push_back(mk(0, 4'b1111, 4'b0010, 4'hD, 1,  1, 1, 4'b0010, 0, 0, 0, 0));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 4'hD, 1, -1, 0, 4'b0000, 0, 1, 0, 0));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 4'hD, 1,  2, 1, 4'b0100, 0, 1, 0, 0));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 4'hD, 1, -1, 0, 4'b0000, 0, 1, 1, 0));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 4'hD, 1,  3, 1, 4'b1000, 0, 1, 1, 0));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 4'hD, 1, -1, 0, 4'b0000, 0, 1, 1, 1));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 4'hD, 1,  0, 1, 4'b0001, 0, 1, 1, 1));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 4'hD, 1, -1, 0, 4'b0000, 1, 1, 1, 1));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 4'hD, 1,  2, 1, 4'b0100, 1, 1, 1, 1));

    foreach (vt[i]) begin
      if (vt[i].rst) do_reset();
      else begin
        @(posedge axis_aclk);
        #1;
      end
      drive(vt[i].tv, vt[i].tl, vt[i].en, vt[i].rdy);
      #3;
      check_out($sformatf("vec%0d", i), vt[i].src, vt[i].e_last, vt[i].e_rdy);
      for (int q = 0; q < NQ; q++)
        chk($sformatf("vec%0d.pkt_cnt%0d", i, q), 256'(pkt_cnt[q*32 +: 32]),
            256'(vt[i].e_cnt[q]));
    end

    // Counter wrap: preload queue 0 counter to all-ones, forward one packet.
    do_reset();
    drive(4'b0000, 4'b0000, 4'hF, 1'b1);
    force dut.g_cnt[0].cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.g_cnt[0].cnt_q;
    #1;
    chk("wrap.preload", 256'(pkt_cnt[31:0]), 256'(32'hFFFF_FFFF));
    step(4'b0001, 4'b0001, 4'hF, 1'b1);
    check_out("wrap.idle", -1, 1'b0, 4'b0000);
    step(4'b0001, 4'b0001, 4'hF, 1'b1);
    check_out("wrap.beat", 0, 1'b1, 4'b0001);
    step(4'b0000, 4'b0000, 4'hF, 1'b1);
    chk("wrap.cnt0", 256'(pkt_cnt[31:0]), 256'(0));
    chk("wrap.cnt_others", 256'(pkt_cnt[127:32]), 256'(0));

    // Reset mid-packet on queue 2 (last grant was 0); queue 0 must win next.
    step(4'b0100, 4'b0000, 4'hF, 1'b1);
    check_out("rst.idle", -1, 1'b0, 4'b0000);
    step(4'b0100, 4'b0000, 4'hF, 1'b1);
    check_out("rst.beat1", 2, 1'b0, 4'b0100);
    #1;
    axis_resetn = 1'b0;
    #1;
    check_out("rst.async", -1, 1'b0, 4'b0000);
    @(posedge axis_aclk);
    #1;
    axis_resetn = 1'b1;
    drive(4'b1111, 4'b0000, 4'hF, 1'b1);
    #3;
    check_out("rst.after_idle", -1, 1'b0, 4'b0000);
    chk("rst.cnt", 256'(pkt_cnt), 256'(0));
    step(4'b1111, 4'b0000, 4'hF, 1'b1);
    check_out("rst.first_grant", 0, 1'b0, 4'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
